// File: rtl/cnn_pkg.sv
// Shared sizing and FSM encoding for the fc1 streaming MAC stage that sits behind conv2/pool2.
package cnn_pkg;
    localparam int CH         = 12;
    localparam int FEAT_W     = 8;
    localparam int W_W        = 4;
    localparam int NUM_VEC    = 16;
    localparam int NUM_OUT    = 10;
    localparam int ACC_W      = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 8;
    localparam int IDX_W      = 4;
    localparam int VEC_W      = CH * FEAT_W;
    localparam int WROW_W     = CH * W_W;
    // zero-extended feature (FEAT_W+1) times signed weight
    localparam int PROD_W     = FEAT_W + 1 + W_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_OUT
    } fc1_state_t;
endpackage

// File: rtl/fc1_feat_fifo.sv
// Small synchronous vector FIFO with registered full/empty; a push is still taken when full
// if a pop happens in the same cycle.
module fc1_feat_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fc1_stream_mac.sv
// Fully-connected layer over a frame of pool2 vectors: one weight row per neuron per vector,
// accumulate per neuron, then stream the NUM_OUT accumulators out one per cycle.
module fc1_stream_mac
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din_valid,
    input  logic [VEC_W-1:0]  data_in,
    input  logic              pool_end,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [WROW_W-1:0] w_data,
    output logic [ACC_W-1:0]  dout,
    output logic [IDX_W-1:0]  dout_idx,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              overflow,
    output logic              frame_err
);
    // Handshake: no backpressure on either side. An input vector is offered on any cycle with
    // din_valid && en; a result beat is delivered on any cycle with dout_valid && en.

    fc1_state_t              state;
    fc1_state_t              state_nxt;
    logic [IDX_W-1:0]        n;
    logic [IDX_W-1:0]        vec_idx;
    logic [4:0]              rx_cnt;
    logic [4:0]              rx_total;
    logic [VEC_W-1:0]        feat_q;
    logic [VEC_W-1:0]        fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic signed [ACC_W-1:0] acc [NUM_OUT];
    logic signed [ACC_W-1:0] dot;
    logic signed [PROD_W-1:0] prod;
    logic [WROW_W-1:0]       w_cur;
    logic [WROW_W-1:0]       w_hold;
    logic                    hold_v;
    logic                    rd_pend;
    logic [ACC_W-1:0]        dout_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_W-1:0]       row_base;
    logic                    last_n;

    assign push     = en && din_valid;
    assign pop      = en && (state == ST_LOAD);
    assign accept   = push && (!fifo_full || pop);
    assign rx_total = rx_cnt + 5'(accept);
    assign last_n   = (n == IDX_W'(NUM_OUT - 1));
    assign row_base = ADDR_W'(vec_idx) * ADDR_W'(NUM_OUT);

    fc1_feat_fifo #(.W(VEC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_MAC;
            ST_MAC: begin
                if (last_n) begin
                    if (vec_idx == IDX_W'(NUM_VEC - 1)) state_nxt = ST_OUT;
                    else if (!fifo_empty)               state_nxt = ST_LOAD;
                    else                                state_nxt = ST_IDLE;
                end
            end
            ST_OUT: if (last_n) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = (state == ST_LOAD) || (state == ST_MAC && !last_n);
        w_addr  = '0;
        if (state == ST_LOAD) begin
            w_addr = row_base;
        end else if (state == ST_MAC && !last_n) begin
            w_addr = row_base + ADDR_W'(n) + ADDR_W'(1);
        end
        dout_valid = (state == ST_OUT);
        frame_done = (state == ST_OUT) && last_n;
        dout       = dout_valid ? acc[n] : dout_q;
        dout_idx   = dout_valid ? n : idx_q;
    end

    // A stall right after a read would let the ROM overwrite the row still owed to MAC; keep it.
    assign w_cur = hold_v ? w_hold : w_data;

    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < CH; k++) begin
            prod = PROD_W'($signed({1'b0, feat_q[k*FEAT_W +: FEAT_W]}))
                 * PROD_W'($signed(w_cur[k*W_W +: W_W]));
            dot  = dot + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n         <= '0;
            vec_idx   <= '0;
            rx_cnt    <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            feat_q    <= '0;
            dout_q    <= '0;
            idx_q     <= '0;
            rd_pend   <= 1'b0;
            hold_v    <= 1'b0;
            w_hold    <= '0;
            for (int i = 0; i < NUM_OUT; i++) acc[i] <= '0;
        end else begin
            rd_pend <= en && w_rd_en;
            if (!en && rd_pend) begin
                w_hold <= w_data;
                hold_v <= 1'b1;
            end else if (en) begin
                hold_v <= 1'b0;
            end
            if (en) begin
                state <= state_nxt;
                if (push && !accept) overflow <= 1'b1;
                if (push && pool_end) begin
                    if (rx_total != 5'(NUM_VEC)) frame_err <= 1'b1;
                    rx_cnt <= '0;
                end else if (accept) begin
                    rx_cnt <= rx_total;
                end
                case (state)
                    ST_LOAD: begin
                        feat_q <= fifo_dout;
                        n      <= '0;
                    end
                    ST_MAC: begin
                        acc[n] <= acc[n] + dot;
                        if (last_n) begin
                            n       <= '0;
                            vec_idx <= (vec_idx == IDX_W'(NUM_VEC - 1)) ? '0 : vec_idx + IDX_W'(1);
                        end else begin
                            n <= n + IDX_W'(1);
                        end
                    end
                    ST_OUT: begin
                        acc[n] <= '0;
                        dout_q <= acc[n];
                        idx_q  <= n;
                        n      <= last_n ? '0 : n + IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fc1_stream_mac.sv
// Directed bench for fc1_stream_mac: ROM model, paced vector driver, and a result scoreboard
// fed with hand-computed per-neuron values.
module tb_fc1_stream_mac;
    import cnn_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              din_valid = 1'b0;
    logic [VEC_W-1:0]  data_in = '0;
    logic              pool_end = 1'b0;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [WROW_W-1:0] w_data = '0;
    logic [ACC_W-1:0]  dout;
    logic [IDX_W-1:0]  dout_idx;
    logic              dout_valid;
    logic              frame_done;
    logic              overflow;
    logic              frame_err;

    logic [WROW_W-1:0] rom [NUM_VEC*NUM_OUT];
    logic [28:0]       exp_q[$];
    logic [28:0]       mon_e;
    int                n_tests = 0;
    int                n_fail = 0;

    fc1_stream_mac dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din_valid  (din_valid),
        .data_in    (data_in),
        .pool_end   (pool_end),
        .w_rd_en    (w_rd_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= rom[w_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every delivered result beat is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && en && dout_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {28'd0, dout_idx}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", {8'd0, dout}, {8'd0, mon_e[23:0]});
                check("dout_idx", {28'd0, dout_idx}, {28'd0, mon_e[27:24]});
                check("frame_done", {31'd0, frame_done}, {31'd0, mon_e[28]});
            end
        end
    end

    // mode 0: all +1, mode 1: all -8, mode 2: neuron n row filled with n-8
    task automatic set_rom(input int mode);
        logic [3:0] v;
        for (int r = 0; r < NUM_VEC*NUM_OUT; r++) begin
            case (mode)
                0:       v = 4'h1;
                1:       v = 4'h8;
                default: v = 4'((r % NUM_OUT) - 8);
            endcase
            rom[r] = {CH{v}};
        end
    endtask

    task automatic push_exp(input int mode);
        logic signed [ACC_W-1:0] v;
        for (int i = 0; i < NUM_OUT; i++) begin
            case (mode)
                0:       v = 24'sd192;
                1:       v = -24'sd391680;
                default: v = ACC_W'((i - 8) * 384);
            endcase
            exp_q.push_back({(i == NUM_OUT - 1), 4'(i), v});
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] f, input logic pe);
        @(posedge clk);
        #1;
        din_valid = 1'b1;
        data_in   = {CH{f}};
        pool_end  = pe;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        pool_end  = 1'b0;
    endtask

    // Called right after a vector was pushed into an idle design: three edges later it sits in
    // MAC with n=1, reading row vec_idx*10+2. Freeze for five cycles and watch nothing move.
    task automatic do_stall(input logic [7:0] exp_addr);
        repeat (3) @(posedge clk);
        #1;
        check("stall_rd_en", {31'd0, w_rd_en}, 32'd1);
        check("stall_addr_pre", {24'd0, w_addr}, {24'd0, exp_addr});
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_addr_held", {24'd0, w_addr}, {24'd0, exp_addr});
            check("stall_rd_en_held", {31'd0, w_rd_en}, 32'd1);
        end
        @(posedge clk);
        #1 en = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] f, input int nvec, input logic pe_last,
                              input int stall_at);
        for (int i = 0; i < nvec; i++) begin
            send_vec(f, pe_last && (i == nvec - 1));
            if (i == stall_at) do_stall(8'(stall_at * NUM_OUT + 2));
            repeat (10) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 800) begin
            @(posedge clk);
            cyc++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        @(negedge clk);
        check("rst_dout", {8'd0, dout}, 32'd0);
        check("rst_dout_idx", {28'd0, dout_idx}, 32'd0);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_w_rd_en", {31'd0, w_rd_en}, 32'd0);
        check("rst_w_addr", {24'd0, w_addr}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);

        // features 1, weights +1 -> 192 everywhere
        set_rom(0);
        push_exp(0);
        send_frame(8'd1, NUM_VEC, 1'b1, -1);
        wait_drain();
        check("ones_overflow", {31'd0, overflow}, 32'd0);
        check("ones_frame_err", {31'd0, frame_err}, 32'd0);
        check("ones_dout_hold", {8'd0, dout}, 32'd192);

        // worst-case negative: 255 * -8 * 12 * 16
        set_rom(1);
        push_exp(1);
        send_frame(8'd255, NUM_VEC, 1'b1, -1);
        wait_drain();

        // per-neuron weights n-8, features 2 -> (n-8)*384
        set_rom(2);
        push_exp(2);
        send_frame(8'd2, NUM_VEC, 1'b1, -1);
        wait_drain();

        // same frame with a five-cycle enable stall mid-MAC on vector 5
        push_exp(2);
        send_frame(8'd2, NUM_VEC, 1'b1, 5);
        wait_drain();
        check("stall_frame_err", {31'd0, frame_err}, 32'd0);

        // reset in the middle of a frame, then a clean frame
        set_rom(0);
        send_frame(8'd1, 7, 1'b0, -1);
        send_vec(8'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_rd_en", {31'd0, w_rd_en}, 32'd1);
        check("pre_rst_dout_hold", {8'd0, dout}, 32'd384);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_w_rd_en", {31'd0, w_rd_en}, 32'd0);
        check("mid_rst_w_addr", {24'd0, w_addr}, 32'd0);
        check("mid_rst_dout", {8'd0, dout}, 32'd0);
        check("mid_rst_dout_idx", {28'd0, dout_idx}, 32'd0);
        check("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        push_exp(0);
        send_frame(8'd1, NUM_VEC, 1'b1, -1);
        wait_drain();

        // short frame: pool_end on the 12th vector
        send_frame(8'd1, 12, 1'b1, -1);
        @(negedge clk);
        check("short_frame_err", {31'd0, frame_err}, 32'd1);
        push_exp(0);
        send_frame(8'd1, NUM_VEC, 1'b1, -1);
        wait_drain();
        check("frame_err_sticky", {31'd0, frame_err}, 32'd1);
        check("short_overflow", {31'd0, overflow}, 32'd0);

        // burst of six back-to-back vectors from idle: the sixth is dropped
        apply_reset();
        @(negedge clk);
        check("rst_clears_frame_err", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            din_valid = 1'b1;
            data_in   = {CH{8'(i + 1)}};
            if (i == 5) begin
                @(negedge clk);
                check("ovf_after_5", {31'd0, overflow}, 32'd0);
            end
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        @(negedge clk);
        check("ovf_after_6", {31'd0, overflow}, 32'd1);
        repeat (120) @(posedge clk);
        @(negedge clk);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_no_frame_err", {31'd0, frame_err}, 32'd0);
        apply_reset();
        @(negedge clk);
        check("rst_clears_overflow", {31'd0, overflow}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc1_stream_mac.md
Name: fc1_stream_mac

Overview:
- Stage directly downstream of the conv2/pool2 pair. Consumes pool2's 96-bit feature vectors: 12 channels x 8-bit unsigned post-ReLU, one vector per spatial position.
- Computes a fully-connected layer of NUM_OUT neurons by streaming MAC against a synchronous weight ROM.
- At the end of a frame, emits one accumulator per cycle to the next classifier stage.

Parameters:
- CH, 12, features per input vector
- FEAT_W, 8, unsigned feature width
- W_W, 4, signed weight width (w_data = CH*W_W = 48 bits)
- NUM_VEC, 16, vectors per frame (4x4 pool2 map)
- NUM_OUT, 10, output neurons
- ACC_W, 24, signed accumulator/output width
- FIFO_DEPTH, 4, input vector buffer depth
- ADDR_W, 8, weight address width, >= clog2(NUM_VEC*NUM_OUT)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low = freeze all state and outputs
- din_valid  in  1  data_in valid (pool2 valid_out)
- data_in  in  96  feature vector; channel k at bits [8k+7:8k]
- pool_end  in  1  pool2 end-of-frame marker; sampled only with din_valid
- w_rd_en  out  1  weight ROM read strobe
- w_addr  out  ADDR_W  weight row address = vec_idx*NUM_OUT + neuron
- w_data  in  48  weight row returned 1 cycle after w_rd_en; weight k at bits [4k+3:4k], signed
- dout  out  ACC_W  neuron result, signed
- dout_idx  out  4  neuron index of dout
- dout_valid  out  1  dout/dout_idx valid
- frame_done  out  1  one-cycle pulse coincident with the last dout
- overflow  out  1  sticky: input vector dropped because the FIFO was full
- frame_err  out  1  sticky: pool_end arrived at received count != NUM_VEC

Behaviour:
- Reset: all outputs 0, FIFO empty, accumulators 0, vec_idx 0, rx_cnt 0, FSM in IDLE, sticky flags cleared.
  - Reset mid-frame abandons the frame; no partial output is emitted.
- en low: no FIFO push/pop, FSM holds, outputs hold their values, and din_valid is ignored (the vector is lost, no flag).
- Input push: din_valid && en.
  - If the FIFO is not full, the vector is pushed.
  - If full and a pop occurs the same cycle, the push is still accepted.
  - Otherwise the vector is dropped and overflow is set.
  - rx_cnt counts accepted vectors.
  - On pool_end, if rx_cnt (including this vector) != NUM_VEC, frame_err is set; rx_cnt then clears regardless.
- FSM states: IDLE, LOAD, MAC, OUT.
  - IDLE: when the FIFO is non-empty, go to LOAD.
  - LOAD (1 cycle): pop the FIFO into the feature register; drive w_rd_en=1 and w_addr=vec_idx*NUM_OUT+0; n=0; go to MAC.
  - MAC (NUM_OUT cycles, n=0..NUM_OUT-1):
    - acc[n] += sum over k of (zero-extended feat[k]) * (signed w[k]); products are 13-bit signed, the sum is sign-extended to ACC_W.
    - While n < NUM_OUT-1, issue the read for n+1.
    - w_rd_en is low on the final MAC cycle.
    - After n = NUM_OUT-1: if vec_idx = NUM_VEC-1, go to OUT with vec_idx cleared; otherwise vec_idx++ and go to LOAD if the FIFO is non-empty, else IDLE.
  - Per-vector throughput: NUM_OUT+1 cycles.
  - OUT (NUM_OUT cycles):
    - dout=acc[i], dout_idx=i, dout_valid=1 for i=0..NUM_OUT-1.
    - frame_done=1 on i=NUM_OUT-1.
    - Each acc[i] is cleared as it is emitted.
    - Then go to IDLE, or LOAD if the FIFO is non-empty.
  - FIFO pushes continue during MAC and OUT.
- dout_valid and frame_done are 0 outside OUT; dout and dout_idx hold their last values.
- Accumulators cannot overflow at the default parameters: worst case 255*8*12*16 = 391680, well below 2^23.
- frame_err and overflow are status only; processing continues.

Decomposition:
- Package cnn_pkg: CH, FEAT_W, W_W, NUM_VEC, NUM_OUT, ACC_W, and the FSM state enum.
- Sub-module fc1_feat_fifo: synchronous FIFO with registered full/empty and same-cycle push+pop when full.
- Dot product and accumulators stay in fc1_stream_mac.

Test Plan:
- Features all 1, ROM weights all +1, 16 vectors with pool_end on the 16th -> dout = 192 for idx 0..9 on 10 consecutive cycles, frame_done on idx 9, flags 0.
- Features all 255, weights all -8 -> every dout = -391680 (0xFA0600 in 24 bits).
- Weight row r = neuron n filled with value n-8, features 2 -> dout[n] = (n-8)*2*12*16 = (n-8)*384.
- 6 vectors on 6 consecutive din_valid cycles from IDLE -> first 5 accepted, the 6th dropped, overflow = 1 and stays high until rst.
- pool_end on the 12th vector -> frame_err = 1. A following full 16-vector frame produces correct outputs; frame_err remains set.
- Cases around en and rst:
  - en low for 5 cycles mid-MAC -> w_addr and outputs frozen; results identical to a run without the stall.
  - rst asserted mid-frame -> all outputs 0 next cycle; the next clean frame gives correct results.
